// File: rtl/uart_fifo.sv
// uart_fifo: 8N1 UART with a small RX FIFO for the J1 I/O space.
//   clk, reset              : system clock, asynchronous active-high reset
//   uart_wr, uart_w         : one-cycle TX strobe and the byte to send
//   uart_rd                 : one-cycle RX pop strobe
//   uart_busy               : transmitter occupied
//   uart_valid, uart_data   : RX FIFO non-empty, head byte (0 when empty)
//   uart_overrun            : sticky, a received byte was dropped on a full FIFO
//   rx, tx                  : serial line in (asynchronous) and out, both idle high
module uart_fifo #(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_wr,
  input  logic       uart_rd,
  input  logic [7:0] uart_w,
  output logic       uart_busy,
  output logic       uart_valid,
  output logic [7:0] uart_data,
  output logic       uart_overrun,
  input  logic       rx,
  output logic       tx
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  tx_state_e           tx_state_q, tx_state_d;
  logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (uart_wr) begin
          tx_shift_d = uart_w;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          busy_d     = 1'b0;
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign tx        = tx_q;
  assign uart_busy = busy_q;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

  logic                rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e           rx_state_q, rx_state_d;
  logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic                push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push       = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_s2_q && rx_prev_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          push       = rx_s2_q;
          rx_state_d = rx_s2_q ? RxIdle : RxWaitHigh;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxWaitHigh: begin
        if (rx_s2_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [AddrW:0] wptr_q, rptr_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic           overrun_q;
  logic           empty, full, pop, wr_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign pop   = uart_rd && !empty;
  // A simultaneous pop frees the head slot, so a full FIFO can still accept.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AddrW + 1)'(1);
      if (pop)   rptr_q <= rptr_q + (AddrW + 1)'(1);
      if (push && full && !pop) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AddrW-1:0]] <= rx_shift_q;
  end

  assign uart_valid   = !empty;
  assign uart_data    = empty ? 8'h00 : mem_q[rptr_q[AddrW-1:0]];
  assign uart_overrun = overrun_q;

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_wr = 1'b0, uart_rd = 1'b0;
  logic [7:0] uart_w = 8'h00;
  logic       uart_busy, uart_valid, uart_overrun, tx;
  logic [7:0] uart_data;
  logic       rx = 1'b1;

  uart_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .uart_wr(uart_wr), .uart_rd(uart_rd), .uart_w(uart_w),
    .uart_busy(uart_busy), .uart_valid(uart_valid), .uart_data(uart_data),
    .uart_overrun(uart_overrun), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  bit rand_en = 0;

  // Behavioural model state
  bit         m_tx_act = 0;
  int         m_tx_off = 0;
  logic [7:0] m_tx_byte = 8'h00;
  logic [7:0] mq[$];
  bit         m_ovr = 0;
  int         push_cyc[$];
  logic [7:0] push_byte[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare against the model, then advance it with this cycle's inputs.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("busy", uart_busy, m_tx_act);
      chk("tx", tx, m_tx_act ? frame_bit(m_tx_byte, (m_tx_off - 1) / CPB) : 1'b1);
      chk("valid", uart_valid, mq.size() != 0);
      chk("data", uart_data, mq.size() != 0 ? mq[0] : 8'h00);
      chk("overrun", uart_overrun, m_ovr);
      if (m_tx_act) begin
        if (m_tx_off == 10 * CPB) m_tx_act = 0;
        else m_tx_off++;
      end else if (uart_wr) begin
        m_tx_act = 1; m_tx_off = 1; m_tx_byte = uart_w;
      end
      if (uart_rd && mq.size() != 0) void'(mq.pop_front());
      if (push_cyc.size() != 0 && push_cyc[0] == cyc) begin
        void'(push_cyc.pop_front());
        if (mq.size() < DEPTH) mq.push_back(push_byte.pop_front());
        else begin m_ovr = 1; void'(push_byte.pop_front()); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    uart_wr = 1'b0;
    uart_rd = 1'b0;
    if (rand_en) begin
      uart_rd = ($urandom_range(0, 15) == 0);
      uart_wr = ($urandom_range(0, 7) == 0);
      uart_w  = 8'($urandom);
    end
  endtask

  // Drives one frame starting this cycle; returns in the stop-bit sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      push_cyc.push_back(cyc + 2 + CPB / 2 + 9 * CPB);
      push_byte.push_back(b);
    end
    for (int k = 0; k < 10; k++) begin
      rx = (k == 9) ? stop : frame_bit(b, k);
      repeat (CPB) tick();
    end
    rx = 1'b1;
  endtask

  task automatic read_expect(input logic [7:0] exp);
    chk("read_valid", uart_valid, 1'b1);
    chk("read_data", uart_data, exp);
    uart_rd = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (uart_busy && guard < 100) begin tick(); guard++; end
    chk("idle_timeout", guard < 100, 1'b1);
  endtask

  logic [9:0] a5_bits = 10'b11_0100_1010;  // frame bits 9..0 for 8'hA5
  int busy_cnt;
  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", uart_busy, 1'b0);
    chk("rst_valid", uart_valid, 1'b0);
    chk("rst_data", uart_data, 8'h00);
    chk("rst_overrun", uart_overrun, 1'b0);
    reset = 1'b0;
    tick();

    // TX of 8'hA5, second strobe 10 cycles in must be ignored
    uart_wr = 1'b1; uart_w = 8'hA5;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (uart_busy) busy_cnt++;
      if (i % CPB == 2 && i / CPB < 10) chk("a5_bit", tx, a5_bits[i / CPB]);
      if (i == 9) begin uart_wr = 1'b1; uart_w = 8'hFF; end
      tick();
    end
    chk("busy_len", busy_cnt, 40);

    // RX 8'h3C with push latency pinned
    send_frame(8'h3C, 1'b1);
    chk("3c_pre_valid", uart_valid, 1'b0);
    tick();
    chk("3c_valid", uart_valid, 1'b1);
    chk("3c_data", uart_data, 8'h3C);
    uart_rd = 1'b1;
    tick();
    chk("3c_pop_valid", uart_valid, 1'b0);
    chk("3c_pop_data", uart_data, 8'h00);

    // Full FIFO, stop-bit sample coincides with a pop
    for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1);
    send_frame(8'h55, 1'b1);
    uart_rd = 1'b1;
    tick();
    chk("coin_overrun", uart_overrun, 1'b0);
    chk("coin_head", uart_data, 8'h22);
    read_expect(8'h22); read_expect(8'h33); read_expect(8'h44); read_expect(8'h55);
    chk("coin_empty", uart_valid, 1'b0);

    // Overrun: five bytes into four slots
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (2) tick();
    chk("ovr_set", uart_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) read_expect(8'(i));
    chk("ovr_empty", uart_valid, 1'b0);

    // Two-cycle glitch is a false start
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (60) tick();
    chk("glitch_empty", uart_valid, 1'b0);

    // Framing error, then a good frame
    send_frame(8'($urandom), 1'b0);
    rx = 1'b0;
    repeat (8) tick();
    rx = 1'b1;
    repeat (8) tick();
    send_frame(8'h7E, 1'b1);
    tick();
    read_expect(8'h7E);
    chk("frame_empty", uart_valid, 1'b0);

    // Random TX strobes and pops around random frames
    rand_en = 1;
    for (int f = 0; f < 10; f++) begin
      send_frame(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 6)) tick();
    end
    rand_en = 0;
    tick();
    for (int g = 0; g < 8 && uart_valid; g++) begin uart_rd = 1'b1; tick(); end
    wait_idle();
    tick();

    // Reset mid-TX (data bit 3) and mid-RX with a byte left in the FIFO
    send_frame(8'h9A, 1'b1);
    tick();
    uart_wr = 1'b1; uart_w = 8'hC3; rx = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      rx = ((i / CPB) % 2 == 1);
    end
    #2;
    reset = 1'b1; rx = 1'b1;
    m_tx_act = 0; mq.delete(); m_ovr = 0; push_cyc.delete(); push_byte.delete();
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", uart_busy, 1'b0);
    chk("mid_rst_valid", uart_valid, 1'b0);
    chk("mid_rst_data", uart_data, 8'h00);
    chk("mid_rst_overrun", uart_overrun, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    uart_wr = 1'b1; uart_w = 8'h55;
    send_frame(8'h55, 1'b1);
    tick();
    read_expect(8'h55);
    wait_idle();
    tick();
    chk("post_busy", uart_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
